sprite_motion_controller: RTL and testbench



---
 rtl/sprite_motion_pkg.sv | 32 +++
 rtl/sprite_motion_controller_if.sv | 26 ++
 rtl/sprite_motion_controller_axis.sv | 126 ++++++++++++
 rtl/sprite_motion_controller.sv | 65 ++++++
 tb/tb_sprite_motion_controller.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_motion_pkg.sv
// Shared types and defaults for the sprite motion controller.
// Direction codes are two's complement so -1/0/+1 read naturally in waves.
package sprite_motion_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    CRUISE = 2'd2
  } axis_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b11
  } dir_e;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_SPRITE_W = 32;
  localparam int DEF_SPRITE_H = 32;
  localparam int DEF_COORD_W  = 10;

  // Both buttons held cancel out; neither side has priority.
  function automatic dir_e decode_dir(input logic neg, input logic pos);
    case ({neg, pos})
      2'b01:   return DIR_POS;
      2'b10:   return DIR_NEG;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sprite_motion_controller_if.sv
// Button inputs and sprite position/status outputs between the controller
// (slave) and whatever drives the buttons and reads the position (master).
interface sprite_motion_controller_if #(
  parameter int COORD_W = 10
);
  logic               btn_left;
  logic               btn_right;
  logic               btn_up;
  logic               btn_down;
  logic               freeze;
  logic [COORD_W-1:0] sprite_x;
  logic [COORD_W-1:0] sprite_y;
  logic               moving;
  logic [3:0]         at_edge;
  logic               tick;

  modport master (
    output btn_left, btn_right, btn_up, btn_down, freeze,
    input  sprite_x, sprite_y, moving, at_edge, tick
  );

  modport slave (
    input  btn_left, btn_right, btn_up, btn_down, freeze,
    output sprite_x, sprite_y, moving, at_edge, tick
  );
endinterface

// File: rtl/sprite_motion_controller_axis.sv
// One axis of sprite motion: IDLE/RAMP/CRUISE speed FSM plus the
// clamp-or-wrap position register. Only acts on unfrozen tick cycles.
module sprite_axis_mover
  import sprite_motion_pkg::*;
#(
  parameter int MAX         = 608,
  parameter int COORD_W     = 10,
  parameter int STEP_MAX    = 4,
  parameter int ACCEL_TICKS = 16,
  parameter int INIT        = 304,
  parameter int WRAP_EN     = 0
) (
  input  logic               clk25,
  input  logic               rst,
  input  logic               tick_i,
  input  logic               freeze_i,
  input  logic               neg_i,
  input  logic               pos_i,
  output logic [COORD_W-1:0] pos_o,
  output logic               moving_o,
  output logic               at_min_o,
  output logic               at_max_o
);

  localparam int                CW        = COORD_W + 1;
  localparam int                HW        = $clog2(ACCEL_TICKS + 1);
  localparam logic [CW-1:0]     MAX_W     = CW'(MAX);
  localparam logic [CW-1:0]     SPAN_W    = CW'(MAX + 1);
  localparam logic [3:0]        STEP_LIM  = 4'(STEP_MAX);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(ACCEL_TICKS - 1);

  axis_state_e        state_q, state_d;
  dir_e               dir_q, dir_d, dir_req;
  logic [3:0]         step_q, step_d, amt;
  logic [HW-1:0]      hold_q, hold_d;
  logic [COORD_W-1:0] pos_q, pos_d;
  logic [CW-1:0]      pos_w, amt_w, up_w;

  assign dir_req = decode_dir(neg_i, pos_i);

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= DIR_NONE;
      step_q  <= 4'd1;
      hold_q  <= '0;
      pos_q   <= COORD_W'(INIT);
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      pos_q   <= pos_d;
    end
  end

  // hold counts moves already made at the current step; the first move out
  // of IDLE counts, so every step value lasts ACCEL_TICKS ticks.
  always_comb begin : next_state
    state_d = state_q;
    dir_d   = dir_q;
    step_d  = step_q;
    hold_d  = hold_q;
    amt     = '0;
    if (tick_i && !freeze_i) begin
      if (dir_req == DIR_NONE) begin
        state_d = IDLE;
        dir_d   = DIR_NONE;
        step_d  = 4'd1;
        hold_d  = '0;
      end else if (state_q == IDLE || dir_req != dir_q) begin
        state_d = RAMP;
        dir_d   = dir_req;
        step_d  = 4'd1;
        hold_d  = HW'(1);
        amt     = 4'd1;
      end else if (state_q == RAMP) begin
        amt = step_q;
        if (step_q >= STEP_LIM) begin
          state_d = CRUISE;
        end else if (hold_q >= HOLD_LAST) begin
          step_d = step_q + 4'd1;
          hold_d = '0;
          if (step_q + 4'd1 >= STEP_LIM) state_d = CRUISE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end else begin
        amt = STEP_LIM;
      end
    end
  end

  // One extra bit exposes underflow/overflow before clamping or wrapping.
  always_comb begin : datapath
    pos_w = {1'b0, pos_q};
    amt_w = CW'(amt);
    up_w  = pos_w + amt_w;
    pos_d = pos_q;
    if (amt != 4'd0) begin
      if (dir_d == DIR_NEG) begin
        if (amt_w > pos_w) begin
          if (WRAP_EN != 0) pos_d = COORD_W'(pos_w + SPAN_W - amt_w);
          else              pos_d = '0;
        end else begin
          pos_d = pos_q - COORD_W'(amt);
        end
      end else begin
        if (up_w > MAX_W) begin
          if (WRAP_EN != 0) pos_d = COORD_W'(up_w - SPAN_W);
          else              pos_d = COORD_W'(MAX_W);
        end else begin
          pos_d = COORD_W'(up_w);
        end
      end
    end
  end

  always_comb begin : outputs
    pos_o    = pos_q;
    moving_o = (state_q != IDLE);
    at_min_o = (pos_q == '0);
    at_max_o = ({1'b0, pos_q} == MAX_W);
  end

endmodule

// File: rtl/sprite_motion_controller.sv
// Two-axis sprite position controller: free-running movement tick, one
// axis mover per coordinate, and edge/motion status packing.
module sprite_motion_controller
  import sprite_motion_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int SPRITE_W    = DEF_SPRITE_W,
  parameter int SPRITE_H    = DEF_SPRITE_H,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int TICK_DIV    = 131072,
  parameter int STEP_MAX    = 4,
  parameter int ACCEL_TICKS = 16,
  parameter int X_INIT      = 304,
  parameter int Y_INIT      = 224,
  parameter int WRAP_EN     = 0
) (
  input logic                     clk25,
  input logic                     rst,
  sprite_motion_controller_if.slave bus
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]      cnt_q, cnt_d;
  logic               tick;
  logic [COORD_W-1:0] x_pos, y_pos;
  logic               x_mov, y_mov, x_min, x_max, y_min, y_max;

  // The tick counter keeps running through freeze.
  always_comb cnt_d = (cnt_q == TICK_LAST) ? '0 : cnt_q + TW'(1);

  always_ff @(posedge clk25) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == TICK_LAST);

  sprite_axis_mover #(
    .MAX(SCREEN_W - SPRITE_W), .COORD_W(COORD_W), .STEP_MAX(STEP_MAX),
    .ACCEL_TICKS(ACCEL_TICKS), .INIT(X_INIT), .WRAP_EN(WRAP_EN)
  ) u_x (
    .clk25(clk25), .rst(rst), .tick_i(tick), .freeze_i(bus.freeze),
    .neg_i(bus.btn_left), .pos_i(bus.btn_right),
    .pos_o(x_pos), .moving_o(x_mov), .at_min_o(x_min), .at_max_o(x_max)
  );

  sprite_axis_mover #(
    .MAX(SCREEN_H - SPRITE_H), .COORD_W(COORD_W), .STEP_MAX(STEP_MAX),
    .ACCEL_TICKS(ACCEL_TICKS), .INIT(Y_INIT), .WRAP_EN(WRAP_EN)
  ) u_y (
    .clk25(clk25), .rst(rst), .tick_i(tick), .freeze_i(bus.freeze),
    .neg_i(bus.btn_up), .pos_i(bus.btn_down),
    .pos_o(y_pos), .moving_o(y_mov), .at_min_o(y_min), .at_max_o(y_max)
  );

  assign bus.sprite_x = x_pos;
  assign bus.sprite_y = y_pos;
  assign bus.moving   = x_mov | y_mov;
  assign bus.at_edge  = {x_max, x_min, y_max, y_min};
  assign bus.tick     = tick;

endmodule

// File: tb/tb_sprite_motion_controller.sv
// Directed bench: clamp and wrap instances share clock, reset and buttons.
module tb_sprite_motion_controller;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk25 = ~clk25;

  sprite_motion_controller_if #(.COORD_W(10)) bc ();
  sprite_motion_controller_if #(.COORD_W(10)) bw ();

  sprite_motion_controller #(
    .TICK_DIV(4), .STEP_MAX(3), .ACCEL_TICKS(2), .WRAP_EN(0)
  ) dut_c (.clk25(clk25), .rst(rst), .bus(bc));

  sprite_motion_controller #(
    .TICK_DIV(4), .STEP_MAX(3), .ACCEL_TICKS(2), .WRAP_EN(1)
  ) dut_w (.clk25(clk25), .rst(rst), .bus(bw));

  task automatic set_btn(input logic l, input logic r, input logic u,
                         input logic d, input logic f);
    bc.btn_left = l; bc.btn_right = r; bc.btn_up = u; bc.btn_down = d; bc.freeze = f;
    bw.btn_left = l; bw.btn_right = r; bw.btn_up = u; bw.btn_down = d; bw.freeze = f;
  endtask

  // Returns at the falling edge just after the tick cycle's rising edge.
  task automatic wait_tick();
    bit seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk25);
      if (bc.tick) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no tick within 8 cycles");
    end
    @(negedge clk25);
  endtask

  task automatic ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk25);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int first = 0;
    set_btn(0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk25);
    checks++;
    if (bc.sprite_x !== 10'd304 || bc.sprite_y !== 10'd224 || bc.moving !== 1'b0 ||
        bc.at_edge !== 4'b0000 || bc.tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got x=%0d y=%0d mov=%b edge=%b tick=%b expected 304 224 0 0000 0",
               bc.sprite_x, bc.sprite_y, bc.moving, bc.at_edge, bc.tick);
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk25);
      if (bc.tick && first == 0) first = k;
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL first_tick: got cycle %0d expected 3", first);
    end
  endtask

  task automatic test_ramp();
    int exp_x[6] = '{305, 306, 308, 310, 313, 316};
    do_reset();
    set_btn(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      wait_tick();
      checks++;
      if (bc.sprite_x !== 10'(exp_x[i]) || bc.moving !== 1'b1) begin
        errors++;
        $display("FAIL ramp_tick%0d: got x=%0d mov=%b expected x=%0d mov=1",
                 i + 1, bc.sprite_x, bc.moving, exp_x[i]);
      end
    end
    set_btn(0, 0, 0, 0, 0);
    wait_tick();
    checks++;
    if (bc.sprite_x !== 10'd316 || bc.moving !== 1'b0) begin
      errors++;
      $display("FAIL ramp_release: got x=%0d mov=%b expected x=316 mov=0", bc.sprite_x, bc.moving);
    end
  endtask

  task automatic test_both_pressed();
    do_reset();
    set_btn(1, 1, 0, 0, 0);
    ticks(3);
    checks++;
    if (bc.sprite_x !== 10'd304 || bc.moving !== 1'b0) begin
      errors++;
      $display("FAIL both_pressed: got x=%0d mov=%b expected x=304 mov=0", bc.sprite_x, bc.moving);
    end
  endtask

  task automatic test_reverse();
    do_reset();
    set_btn(0, 1, 0, 0, 0);
    ticks(8);
    checks++;
    if (bc.sprite_x !== 10'd322) begin
      errors++;
      $display("FAIL cruise_x: got %0d expected 322", bc.sprite_x);
    end
    set_btn(1, 0, 0, 0, 0);
    wait_tick();
    checks++;
    if (bc.sprite_x !== 10'd321) begin
      errors++;
      $display("FAIL reverse_first: got %0d expected 321", bc.sprite_x);
    end
    wait_tick();
    checks++;
    if (bc.sprite_x !== 10'd320) begin
      errors++;
      $display("FAIL reverse_second: got %0d expected 320", bc.sprite_x);
    end
  endtask

  task automatic test_diagonal();
    do_reset();
    set_btn(0, 1, 0, 1, 0);
    ticks(4);
    checks++;
    if (bc.sprite_x !== 10'd310 || bc.sprite_y !== 10'd230 || bc.at_edge !== 4'b0000) begin
      errors++;
      $display("FAIL diagonal: got x=%0d y=%0d edge=%b expected 310 230 0000",
               bc.sprite_x, bc.sprite_y, bc.at_edge);
    end
  endtask

  task automatic test_freeze();
    int exp_x[3] = '{308, 310, 313};
    do_reset();
    set_btn(0, 1, 0, 0, 0);
    ticks(2);
    set_btn(0, 1, 0, 0, 1);
    ticks(3);
    checks++;
    if (bc.sprite_x !== 10'd306 || bc.moving !== 1'b1) begin
      errors++;
      $display("FAIL freeze_hold: got x=%0d mov=%b expected x=306 mov=1", bc.sprite_x, bc.moving);
    end
    set_btn(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      checks++;
      if (bc.sprite_x !== 10'(exp_x[i])) begin
        errors++;
        $display("FAIL freeze_resume%0d: got %0d expected %0d", i, bc.sprite_x, exp_x[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_btn(0, 1, 0, 0, 0);
    ticks(8);
    rst = 1'b1;
    @(negedge clk25);
    checks++;
    if (bc.sprite_x !== 10'd304 || bc.sprite_y !== 10'd224 || bc.moving !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got x=%0d y=%0d mov=%b expected 304 224 0",
               bc.sprite_x, bc.sprite_y, bc.moving);
    end
    rst = 1'b0;
    wait_tick();
    checks++;
    if (bc.sprite_x !== 10'd305) begin
      errors++;
      $display("FAIL reset_mid_step1: got %0d expected 305", bc.sprite_x);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    set_btn(1, 0, 0, 0, 0);
    ticks(6);
    checks++;
    if (bc.sprite_x !== 10'd292) begin
      errors++;
      $display("FAIL clamp_ramp_left: got %0d expected 292", bc.sprite_x);
    end
    ticks(104);
    checks++;
    if (bc.sprite_x !== 10'd0 || bc.at_edge !== 4'b0100 || bc.moving !== 1'b1) begin
      errors++;
      $display("FAIL clamp_left: got x=%0d edge=%b mov=%b expected 0 0100 1",
               bc.sprite_x, bc.at_edge, bc.moving);
    end
    ticks(2);
    checks++;
    if (bc.sprite_x !== 10'd0) begin
      errors++;
      $display("FAIL clamp_left_hold: got %0d expected 0", bc.sprite_x);
    end
    set_btn(0, 1, 0, 0, 0);
    ticks(215);
    checks++;
    if (bc.sprite_x !== 10'd608 || bc.at_edge !== 4'b1000) begin
      errors++;
      $display("FAIL clamp_right: got x=%0d edge=%b expected 608 1000", bc.sprite_x, bc.at_edge);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_btn(0, 1, 0, 0, 0);
    ticks(103);
    checks++;
    if (bw.sprite_x !== 10'd607) begin
      errors++;
      $display("FAIL wrap_pre_right: got %0d expected 607", bw.sprite_x);
    end
    wait_tick();
    checks++;
    if (bw.sprite_x !== 10'd1) begin
      errors++;
      $display("FAIL wrap_right: got %0d expected 1", bw.sprite_x);
    end
    do_reset();
    set_btn(1, 0, 0, 0, 0);
    ticks(103);
    checks++;
    if (bw.sprite_x !== 10'd1) begin
      errors++;
      $display("FAIL wrap_pre_left: got %0d expected 1", bw.sprite_x);
    end
    wait_tick();
    checks++;
    if (bw.sprite_x !== 10'd607) begin
      errors++;
      $display("FAIL wrap_left: got %0d expected 607", bw.sprite_x);
    end
  endtask

  initial begin
    set_btn(0, 0, 0, 0, 0);
    test_reset();
    test_ramp();
    test_both_pressed();
    test_reverse();
    test_diagonal();
    test_freeze();
    test_reset_mid();
    test_clamp();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
